// File: rtl/if_stage_ifid_pkg.sv
// Shared pipeline definitions for the fetch stage and its consumers.
// IF/ID bundle, opcodes and bubble/halt words live here.
package if_stage_ifid_pkg;

   localparam int          PKG_XLEN = 64;
   localparam logic [31:0] PKG_NOP  = 32'h0000_0013;
   localparam logic [31:0] PKG_HALT = 32'h0000_0000;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef struct packed {
      logic [PKG_XLEN-1:0] pc;
      logic [31:0]         instr;
      logic                valid;
   } ifid_t;

   typedef enum logic {
      ST_RUN,
      ST_HALT
   } fetch_st_t;

   typedef enum logic [1:0] {
      SEL_BRANCH,
      SEL_STALL,
      SEL_HOLD,
      SEL_SEQ
   } pc_sel_t;

endpackage

// File: rtl/if_stage_ifid_pc_next_sel.sv
// Next-PC priority mux: redirect, stall, halt hold, sequential.
// The selected source also steers the IF/ID update in the top.
module if_stage_ifid_pc_next_sel
   import if_stage_ifid_pkg::*;
#(
   parameter int XLEN = PKG_XLEN
) (
   input  logic [XLEN-1:0] pc,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   input  logic            stall,
   input  logic            hold,
   output logic [XLEN-1:0] pc_next,
   output pc_sel_t         sel,
   output logic            target_misaligned
);

   // Overlapping requests are legal, so this must be a priority decode.
   always_comb begin
      sel = SEL_SEQ;
      priority case (1'b1)
         branch_taken: sel = SEL_BRANCH;
         stall:        sel = SEL_STALL;
         hold:         sel = SEL_HOLD;
         default:      sel = SEL_SEQ;
      endcase
   end

   always_comb begin
      pc_next = pc;
      unique case (sel)
         SEL_BRANCH: pc_next = {branch_target[XLEN-1:2], 2'b00};
         SEL_SEQ:    pc_next = pc + XLEN'(4);
         default:    pc_next = pc;
      endcase
   end

   assign target_misaligned = branch_taken && (branch_target[1:0] != 2'b00);

endmodule

// File: rtl/if_stage_ifid.sv
// Instruction fetch stage with the IF/ID pipeline register.
// Owns the PC, honours stall/flush, stops on the halt word.
module if_stage_ifid
   import if_stage_ifid_pkg::*;
#(
   parameter int               XLEN       = PKG_XLEN,
   parameter logic [XLEN-1:0]  RESET_PC   = '0,
   parameter logic [31:0]      NOP_INSTR  = PKG_NOP,
   parameter logic [31:0]      HALT_INSTR = PKG_HALT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] ifid_pc,
   output logic [31:0]     ifid_instr,
   output logic            ifid_valid,
   output logic            halted,
   output logic            misaligned,
   output logic [31:0]     fetch_count
);

   fetch_st_t       state;
   fetch_st_t       state_next;
   pc_sel_t         sel;
   ifid_t           ifid_q;
   logic [XLEN-1:0] pc_next;
   logic            halt_word;
   logic            hold;
   logic            target_mis;

   assign halt_word = (imem_rdata == HALT_INSTR);
   assign hold      = (state == ST_HALT) || halt_word;
   assign imem_addr = pc;

   if_stage_ifid_pc_next_sel #(
      .XLEN (XLEN)
   ) u_sel (
      .pc                (pc),
      .branch_taken      (branch_taken),
      .branch_target     (branch_target),
      .stall             (stall),
      .hold              (hold),
      .pc_next           (pc_next),
      .sel               (sel),
      .target_misaligned (target_mis)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_RUN;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         ST_RUN:  if (sel == SEL_HOLD) state_next = ST_HALT;
         ST_HALT: if (branch_taken)    state_next = ST_RUN;
         default: state_next = ST_RUN;
      endcase
   end

   always_comb begin
      halted = (state == ST_HALT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc          <= RESET_PC;
         ifid_q      <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
         misaligned  <= 1'b0;
         fetch_count <= '0;
      end else begin
         pc <= pc_next;
         if (target_mis) misaligned <= 1'b1;
         unique case (sel)
            SEL_BRANCH: ifid_q <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
            SEL_STALL:  ifid_q <= ifid_q;
            SEL_HOLD: begin
               ifid_q.instr <= NOP_INSTR;
               ifid_q.valid <= 1'b0;
            end
            SEL_SEQ: begin
               ifid_q      <= '{pc: pc, instr: imem_rdata, valid: 1'b1};
               fetch_count <= fetch_count + 32'd1;
            end
            default: ifid_q <= ifid_q;
         endcase
      end
   end

   assign ifid_pc    = ifid_q.pc;
   assign ifid_instr = ifid_q.instr;
   assign ifid_valid = ifid_q.valid;

endmodule

// File: tb/tb_if_stage_ifid.sv
// Directed bench for if_stage_ifid with a small combinational imem.
// Each scenario task drives stimulus and checks its own expectations.
module tb_if_stage_ifid;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [63:0] branch_target;
   logic [63:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [63:0] pc;
   logic [63:0] ifid_pc;
   logic [31:0] ifid_instr;
   logic        ifid_valid;
   logic        halted;
   logic        misaligned;
   logic [31:0] fetch_count;

   logic [31:0] mem [64];
   int checks;
   int failures;

   if_stage_ifid dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .pc            (pc),
      .ifid_pc       (ifid_pc),
      .ifid_instr    (ifid_instr),
      .ifid_valid    (ifid_valid),
      .halted        (halted),
      .misaligned    (misaligned),
      .fetch_count   (fetch_count)
   );

   assign imem_rdata =
      (imem_addr[63:8] == '0 && imem_addr[1:0] == 2'b00) ?
      mem[imem_addr[7:2]] : 32'h0000_0013;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (pc !== 64'h0) begin
         failures++;
         $display("FAIL reset_pc got=%h exp=%h", pc, 64'h0);
      end
      checks++;
      if (imem_addr !== 64'h0) begin
         failures++;
         $display("FAIL reset_imem_addr got=%h exp=%h", imem_addr, 64'h0);
      end
      checks++;
      if (ifid_instr !== 32'h13 || ifid_valid !== 1'b0 || ifid_pc !== 64'h0) begin
         failures++;
         $display("FAIL reset_ifid got=%h/%b/%h exp=00000013/0/0",
                  ifid_instr, ifid_valid, ifid_pc);
      end
      checks++;
      if (halted !== 1'b0 || misaligned !== 1'b0 || fetch_count !== 32'd0) begin
         failures++;
         $display("FAIL reset_flags got=%b/%b/%0d exp=0/0/0",
                  halted, misaligned, fetch_count);
      end
      reset = 1'b0;
   endtask

   task automatic test_straight_line();
      tick();
      checks++;
      if (pc !== 64'h4 || ifid_instr !== 32'h00A00093 ||
          ifid_pc !== 64'h0 || ifid_valid !== 1'b1) begin
         failures++;
         $display("FAIL seq0 got=%h/%h/%h/%b exp=4/00a00093/0/1",
                  pc, ifid_instr, ifid_pc, ifid_valid);
      end
      tick();
      checks++;
      if (pc !== 64'h8 || ifid_instr !== 32'h00B00113 ||
          ifid_pc !== 64'h4 || fetch_count !== 32'd2) begin
         failures++;
         $display("FAIL seq1 got=%h/%h/%h/%0d exp=8/00b00113/4/2",
                  pc, ifid_instr, ifid_pc, fetch_count);
      end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (pc !== 64'h8 || ifid_instr !== 32'h00B00113 ||
             ifid_pc !== 64'h4 || fetch_count !== 32'd2) begin
            failures++;
            $display("FAIL stall_hold%0d got=%h/%h/%h/%0d exp=8/00b00113/4/2",
                     i, pc, ifid_instr, ifid_pc, fetch_count);
         end
      end
      stall = 1'b0;
      tick();
      checks++;
      if (pc !== 64'hC || ifid_instr !== 32'h002081B3 ||
          ifid_pc !== 64'h8 || fetch_count !== 32'd3) begin
         failures++;
         $display("FAIL stall_resume got=%h/%h/%h/%0d exp=c/002081b3/8/3",
                  pc, ifid_instr, ifid_pc, fetch_count);
      end
   endtask

   task automatic test_flush_beats_stall();
      branch_taken  = 1'b1;
      stall         = 1'b1;
      branch_target = 64'h40;
      tick();
      checks++;
      if (pc !== 64'h40 || ifid_valid !== 1'b0 ||
          ifid_instr !== 32'h13 || ifid_pc !== 64'h0) begin
         failures++;
         $display("FAIL flush got=%h/%b/%h/%h exp=40/0/00000013/0",
                  pc, ifid_valid, ifid_instr, ifid_pc);
      end
      checks++;
      if (fetch_count !== 32'd3) begin
         failures++;
         $display("FAIL flush_count got=%0d exp=3", fetch_count);
      end
      branch_taken = 1'b0;
      stall        = 1'b0;
      tick();
      checks++;
      if (pc !== 64'h44 || ifid_pc !== 64'h40 ||
          ifid_valid !== 1'b1 || fetch_count !== 32'd4) begin
         failures++;
         $display("FAIL post_flush got=%h/%h/%b/%0d exp=44/40/1/4",
                  pc, ifid_pc, ifid_valid, fetch_count);
      end
   endtask

   task automatic test_misaligned();
      checks++;
      if (misaligned !== 1'b0) begin
         failures++;
         $display("FAIL mis_pre got=%b exp=0", misaligned);
      end
      branch_taken  = 1'b1;
      branch_target = 64'h42;
      tick();
      checks++;
      if (pc !== 64'h40 || misaligned !== 1'b1) begin
         failures++;
         $display("FAIL mis_set got=%h/%b exp=40/1", pc, misaligned);
      end
      branch_target = 64'h8;
      tick();
      checks++;
      if (pc !== 64'h8 || misaligned !== 1'b1) begin
         failures++;
         $display("FAIL mis_sticky got=%h/%b exp=8/1", pc, misaligned);
      end
      branch_taken = 1'b0;
      tick();
      checks++;
      if (pc !== 64'hC || misaligned !== 1'b1) begin
         failures++;
         $display("FAIL mis_sticky2 got=%h/%b exp=c/1", pc, misaligned);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (misaligned !== 1'b0 || pc !== 64'h0) begin
         failures++;
         $display("FAIL mis_clear got=%b/%h exp=0/0", misaligned, pc);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_halt();
      mem[4] = 32'h0000_0000;
      repeat (4) tick();
      checks++;
      if (pc !== 64'h10 || halted !== 1'b0 || fetch_count !== 32'd4) begin
         failures++;
         $display("FAIL halt_pre got=%h/%b/%0d exp=10/0/4",
                  pc, halted, fetch_count);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (halted !== 1'b1 || pc !== 64'h10 || ifid_valid !== 1'b0 ||
             ifid_instr !== 32'h13 || fetch_count !== 32'd4) begin
            failures++;
            $display("FAIL halt%0d got=%b/%h/%b/%h/%0d exp=1/10/0/00000013/4",
                     i, halted, pc, ifid_valid, ifid_instr, fetch_count);
         end
      end
      branch_taken  = 1'b1;
      branch_target = 64'h0;
      tick();
      checks++;
      if (halted !== 1'b0 || pc !== 64'h0 || ifid_valid !== 1'b0) begin
         failures++;
         $display("FAIL halt_exit got=%b/%h/%b exp=0/0/0",
                  halted, pc, ifid_valid);
      end
      branch_taken = 1'b0;
      tick();
      checks++;
      if (pc !== 64'h4 || ifid_instr !== 32'h00A00093 ||
          ifid_valid !== 1'b1 || fetch_count !== 32'd5) begin
         failures++;
         $display("FAIL halt_restart got=%h/%h/%b/%0d exp=4/00a00093/1/5",
                  pc, ifid_instr, ifid_valid, fetch_count);
      end
   endtask

   task automatic test_async_reset();
      mem[4] = 32'h0000_0013;
      repeat (7) tick();
      checks++;
      if (pc !== 64'h20 || halted !== 1'b0 || fetch_count !== 32'd12) begin
         failures++;
         $display("FAIL arst_pre got=%h/%b/%0d exp=20/0/12",
                  pc, halted, fetch_count);
      end
      #3;
      reset = 1'b1;
      #1;
      checks++;
      if (pc !== 64'h0 || fetch_count !== 32'd0 || halted !== 1'b0) begin
         failures++;
         $display("FAIL arst_pc got=%h/%0d/%b exp=0/0/0",
                  pc, fetch_count, halted);
      end
      checks++;
      if (ifid_valid !== 1'b0 || ifid_instr !== 32'h13 || ifid_pc !== 64'h0) begin
         failures++;
         $display("FAIL arst_ifid got=%b/%h/%h exp=0/00000013/0",
                  ifid_valid, ifid_instr, ifid_pc);
      end
      @(negedge clk);
      reset = 1'b0;
      tick();
      checks++;
      if (pc !== 64'h4 || ifid_instr !== 32'h00A00093 || fetch_count !== 32'd1) begin
         failures++;
         $display("FAIL arst_restart got=%h/%h/%0d exp=4/00a00093/1",
                  pc, ifid_instr, fetch_count);
      end
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      reset         = 1'b1;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = '0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
      mem[0] = 32'h00A00093;
      mem[1] = 32'h00B00113;
      mem[2] = 32'h002081B3;

      test_reset();
      test_straight_line();
      test_stall();
      test_flush_beats_stall();
      test_misaligned();
      test_halt();
      test_async_reset();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
